// File: rtl/int_reg_wb_arbiter_pkg.sv
// Shared sizing, payload types and scan-order helper for the integer
// arch-reg writeback arbiter.
package int_reg_wb_arbiter_pkg;

  localparam int unsigned NUM_REQ    = 4;
  localparam int unsigned NUM_PORTS  = 2;
  localparam int unsigned IDX_W      = 5;
  localparam int unsigned DATA_W     = 64;
  localparam int unsigned TAG_W      = 6;
  localparam int unsigned PTR_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned PORT_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned WB_REQ_NUM = NUM_REQ;

  typedef struct packed {
    logic              valid;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
  } wb_req_t;

  typedef struct packed {
    logic              valid;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
  } int_arch_reg_write_t;

  // Position of requester r in the round-robin scan that starts at ptr.
  function automatic int unsigned scan_pos(input int unsigned r, input logic [PTR_W-1:0] ptr);
    return (r + NUM_REQ - 32'(ptr)) % NUM_REQ;
  endfunction

endpackage

// File: rtl/int_reg_wb_arbiter_rr_multi_picker.sv
// Round-robin picker: grants up to NUM_PORTS eligible requesters in scan
// order from rr_ptr and returns the pointer just past the last grant.
module rr_multi_picker
  import int_reg_wb_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0]                eligible,
  input  logic [PTR_W-1:0]                  rr_ptr,
  output logic [NUM_PORTS-1:0][NUM_REQ-1:0] grant,
  output logic [NUM_PORTS-1:0]              grant_valid,
  output logic [PTR_W-1:0]                  next_ptr
);

  int unsigned n_granted;
  int unsigned cand;

  always_comb begin
    grant       = '0;
    grant_valid = '0;
    next_ptr    = rr_ptr;
    n_granted   = 0;
    cand        = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = (32'(rr_ptr) + k) % NUM_REQ;
      if (eligible[PTR_W'(cand)] && (n_granted < NUM_PORTS)) begin
        grant[PORT_W'(n_granted)][PTR_W'(cand)] = 1'b1;
        grant_valid[PORT_W'(n_granted)]         = 1'b1;
        next_ptr                                = PTR_W'((cand + 1) % NUM_REQ);
        n_granted                               = n_granted + 1;
      end
    end
  end

endmodule

// File: rtl/int_reg_wb_arbiter.sv
// Buffers one writeback result per functional unit and drives up to
// NUM_PORTS speculative arch-reg writes per cycle, round-robin.
module int_reg_wb_arbiter
  import int_reg_wb_arbiter_pkg::*;
(
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic                             i_recover,
  input  logic [NUM_REQ-1:0]               i_req_valid,
  input  logic [NUM_REQ-1:0][IDX_W-1:0]    i_req_idx,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]   i_req_data,
  input  logic [NUM_REQ-1:0][TAG_W-1:0]    i_req_tag,
  output logic [NUM_REQ-1:0]               o_req_ready,
  input  logic                             i_wb_stall,
  output logic [NUM_PORTS-1:0]             o_wb_valid,
  output logic [NUM_PORTS-1:0][IDX_W-1:0]  o_wb_idx,
  output logic [NUM_PORTS-1:0][DATA_W-1:0] o_wb_data,
  output logic [NUM_PORTS-1:0][TAG_W-1:0]  o_wb_tag
);

  wb_req_t             [NUM_REQ-1:0]              buf_q;
  int_arch_reg_write_t [NUM_PORTS-1:0]            wb_q;
  int_arch_reg_write_t [NUM_PORTS-1:0]            wb_d;
  logic                [PTR_W-1:0]                rr_ptr_q;
  logic                [PTR_W-1:0]                next_ptr;
  logic                [NUM_REQ-1:0]              buf_valid;
  logic                [NUM_REQ-1:0]              live;
  logic                [NUM_REQ-1:0]              eligible;
  logic                [NUM_REQ-1:0]              granted;
  logic                [NUM_PORTS-1:0][NUM_REQ-1:0] grant;
  logic                [NUM_PORTS-1:0]            grant_valid;

  // A live entry loses to an earlier live entry (in scan order) with the same idx.
  always_comb begin
    for (int unsigned r = 0; r < NUM_REQ; r++) begin
      buf_valid[PTR_W'(r)] = buf_q[PTR_W'(r)].valid;
      live[PTR_W'(r)]      = buf_q[PTR_W'(r)].valid && (buf_q[PTR_W'(r)].idx != '0);
    end
    eligible = live;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (live[PTR_W'(i)] && live[PTR_W'(j)] &&
            (buf_q[PTR_W'(i)].idx == buf_q[PTR_W'(j)].idx) &&
            (scan_pos(i, rr_ptr_q) < scan_pos(j, rr_ptr_q))) begin
          eligible[PTR_W'(j)] = 1'b0;
        end
      end
    end
  end

  rr_multi_picker u_picker (
    .eligible    (eligible),
    .rr_ptr      (rr_ptr_q),
    .grant       (grant),
    .grant_valid (grant_valid),
    .next_ptr    (next_ptr)
  );

  // Route granted buffers onto ports; idle ports keep their last payload.
  always_comb begin
    wb_d    = wb_q;
    granted = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      wb_d[PORT_W'(p)].valid = grant_valid[PORT_W'(p)];
      for (int unsigned r = 0; r < NUM_REQ; r++) begin
        if (grant[PORT_W'(p)][PTR_W'(r)]) begin
          wb_d[PORT_W'(p)].idx  = buf_q[PTR_W'(r)].idx;
          wb_d[PORT_W'(p)].data = buf_q[PTR_W'(r)].data;
          wb_d[PORT_W'(p)].tag  = buf_q[PTR_W'(r)].tag;
          granted[PTR_W'(r)]    = 1'b1;
        end
      end
    end
  end

  assign o_req_ready = ~buf_valid & {NUM_REQ{~i_recover & i_rst_n}};

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      buf_q    <= '0;
      wb_q     <= '0;
      rr_ptr_q <= '0;
    end else if (i_recover) begin
      for (int unsigned r = 0; r < NUM_REQ; r++) buf_q[PTR_W'(r)].valid <= 1'b0;
      for (int unsigned p = 0; p < NUM_PORTS; p++) wb_q[PORT_W'(p)].valid <= 1'b0;
      rr_ptr_q <= '0;
    end else begin
      for (int unsigned r = 0; r < NUM_REQ; r++) begin
        // Granted and x0 entries retire in the scan cycle; empty buffers accept.
        if (!i_wb_stall && (granted[PTR_W'(r)] || (buf_valid[PTR_W'(r)] && !live[PTR_W'(r)]))) begin
          buf_q[PTR_W'(r)].valid <= 1'b0;
        end else if (!buf_valid[PTR_W'(r)] && i_req_valid[PTR_W'(r)]) begin
          buf_q[PTR_W'(r)] <= '{valid: 1'b1,
                                idx:   i_req_idx[PTR_W'(r)],
                                data:  i_req_data[PTR_W'(r)],
                                tag:   i_req_tag[PTR_W'(r)]};
        end
      end
      if (!i_wb_stall) begin
        wb_q     <= wb_d;
        rr_ptr_q <= next_ptr;
      end
    end
  end

  always_comb begin
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      o_wb_valid[PORT_W'(p)] = wb_q[PORT_W'(p)].valid;
      o_wb_idx[PORT_W'(p)]   = wb_q[PORT_W'(p)].idx;
      o_wb_data[PORT_W'(p)]  = wb_q[PORT_W'(p)].data;
      o_wb_tag[PORT_W'(p)]   = wb_q[PORT_W'(p)].tag;
    end
  end

endmodule

// File: tb/tb_int_reg_wb_arbiter.sv
// Directed table-driven bench for int_reg_wb_arbiter.
module tb_int_reg_wb_arbiter;
  import int_reg_wb_arbiter_pkg::*;

  typedef struct {
    logic            rec;
    logic            stall;
    logic [3:0]      rv;
    logic [3:0][4:0] idx;
    logic [3:0][5:0] tag;
    logic [3:0]      rdy;
    logic [1:0]      wv;
    logic [1:0][4:0] widx;
    logic [1:0][5:0] wtag;
  } vec_t;

  logic                             clk = 1'b0;
  logic                             rst_n = 1'b0;
  logic                             recover;
  logic                             stall;
  logic [NUM_REQ-1:0]               req_valid;
  logic [NUM_REQ-1:0][IDX_W-1:0]    req_idx;
  logic [NUM_REQ-1:0][DATA_W-1:0]   req_data;
  logic [NUM_REQ-1:0][TAG_W-1:0]    req_tag;
  logic [NUM_REQ-1:0]               ready;
  logic [NUM_PORTS-1:0]             wb_valid;
  logic [NUM_PORTS-1:0][IDX_W-1:0]  wb_idx;
  logic [NUM_PORTS-1:0][DATA_W-1:0] wb_data;
  logic [NUM_PORTS-1:0][TAG_W-1:0]  wb_tag;

  int   passed = 0;
  int   total  = 0;
  vec_t vq[$];
  vec_t cur;

  int_reg_wb_arbiter dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_recover   (recover),
    .i_req_valid (req_valid),
    .i_req_idx   (req_idx),
    .i_req_data  (req_data),
    .i_req_tag   (req_tag),
    .o_req_ready (ready),
    .i_wb_stall  (stall),
    .o_wb_valid  (wb_valid),
    .o_wb_idx    (wb_idx),
    .o_wb_data   (wb_data),
    .o_wb_tag    (wb_tag)
  );

  always #5 clk = ~clk;

  // Data is tied to the tag so a wrong source shows up in every field.
  function automatic logic [63:0] data_of(input logic [5:0] t);
    return 64'hAF ^ 64'(t);
  endfunction

  function automatic vec_t mk(input int rec, input int st, input logic [3:0] rv,
                              input int i0, input int i1, input int i2, input int i3,
                              input int t0, input int t1, input int t2, input int t3,
                              input logic [3:0] rdy, input logic [1:0] wv,
                              input int wi0, input int wt0, input int wi1, input int wt1);
    vec_t v;
    v.rec = 1'(rec);  v.stall = 1'(st);  v.rv = rv;
    v.idx[0] = 5'(i0); v.idx[1] = 5'(i1); v.idx[2] = 5'(i2); v.idx[3] = 5'(i3);
    v.tag[0] = 6'(t0); v.tag[1] = 6'(t1); v.tag[2] = 6'(t2); v.tag[3] = 6'(t3);
    v.rdy = rdy; v.wv = wv;
    v.widx[0] = 5'(wi0); v.wtag[0] = 6'(wt0);
    v.widx[1] = 5'(wi1); v.wtag[1] = 6'(wt1);
    return v;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic apply(input vec_t v);
    recover   = v.rec;
    stall     = v.stall;
    req_valid = v.rv;
    req_idx   = v.idx;
    req_tag   = v.tag;
    for (int r = 0; r < 4; r++) req_data[r] = data_of(v.tag[r]);
  endtask

  initial begin
    //               rec st rv       idx0..3        tag0..3          rdy      wv     p0       p1
    vq.push_back(mk(0, 0, 4'b0000,  0, 0, 0, 0,   0, 0, 0, 0,     4'b1111, 2'b00,  0, 0,   0, 0));
    vq.push_back(mk(0, 0, 4'b0001,  3, 0, 0, 0,   5, 0, 0, 0,     4'b1111, 2'b00,  0, 0,   0, 0));
    vq.push_back(mk(0, 0, 4'b0000,  0, 0, 0, 0,   0, 0, 0, 0,     4'b1110, 2'b00,  0, 0,   0, 0));
    vq.push_back(mk(0, 0, 4'b0000,  0, 0, 0, 0,   0, 0, 0, 0,     4'b1111, 2'b01,  3, 5,   0, 0));
    vq.push_back(mk(1, 0, 4'b0000,  0, 0, 0, 0,   0, 0, 0, 0,     4'b0000, 2'b00,  0, 0,   0, 0));
    // all four requesters, rr from 0
    vq.push_back(mk(0, 0, 4'b1111,  1, 2, 3, 4,  10,11,12,13,     4'b1111, 2'b00,  0, 0,   0, 0));
    vq.push_back(mk(0, 0, 4'b0000,  0, 0, 0, 0,   0, 0, 0, 0,     4'b0000, 2'b00,  0, 0,   0, 0));
    vq.push_back(mk(0, 0, 4'b0000,  0, 0, 0, 0,   0, 0, 0, 0,     4'b0011, 2'b11,  1,10,   2,11));
    vq.push_back(mk(0, 0, 4'b0000,  0, 0, 0, 0,   0, 0, 0, 0,     4'b1111, 2'b11,  3,12,   4,13));
    // idx conflict between req1 and req2
    vq.push_back(mk(0, 0, 4'b0110,  0, 7, 7, 0,   0,21,22, 0,     4'b1111, 2'b00,  0, 0,   0, 0));
    vq.push_back(mk(0, 0, 4'b0000,  0, 0, 0, 0,   0, 0, 0, 0,     4'b1001, 2'b00,  0, 0,   0, 0));
    vq.push_back(mk(0, 0, 4'b0000,  0, 0, 0, 0,   0, 0, 0, 0,     4'b1011, 2'b01,  7,21,   0, 0));
    vq.push_back(mk(0, 0, 4'b0000,  0, 0, 0, 0,   0, 0, 0, 0,     4'b1111, 2'b01,  7,22,   0, 0));
    // x0 entry alongside a real write
    vq.push_back(mk(0, 0, 4'b0011,  0, 9, 0, 0,  30,31, 0, 0,     4'b1111, 2'b00,  0, 0,   0, 0));
    vq.push_back(mk(0, 0, 4'b0000,  0, 0, 0, 0,   0, 0, 0, 0,     4'b1100, 2'b00,  0, 0,   0, 0));
    vq.push_back(mk(0, 0, 4'b0000,  0, 0, 0, 0,   0, 0, 0, 0,     4'b1111, 2'b01,  9,31,   0, 0));
    // lone x0 must leave rr_ptr at 2
    vq.push_back(mk(0, 0, 4'b0001,  0, 0, 0, 0,  33, 0, 0, 0,     4'b1111, 2'b00,  0, 0,   0, 0));
    vq.push_back(mk(0, 0, 4'b0000,  0, 0, 0, 0,   0, 0, 0, 0,     4'b1110, 2'b00,  0, 0,   0, 0));
    vq.push_back(mk(0, 0, 4'b0110,  0, 5, 5, 0,   0,41,42, 0,     4'b1111, 2'b00,  0, 0,   0, 0));
    vq.push_back(mk(0, 0, 4'b0000,  0, 0, 0, 0,   0, 0, 0, 0,     4'b1001, 2'b00,  0, 0,   0, 0));
    vq.push_back(mk(0, 0, 4'b0000,  0, 0, 0, 0,   0, 0, 0, 0,     4'b1101, 2'b01,  5,42,   0, 0));
    vq.push_back(mk(0, 0, 4'b0000,  0, 0, 0, 0,   0, 0, 0, 0,     4'b1111, 2'b01,  5,41,   0, 0));
    vq.push_back(mk(0, 0, 4'b0000,  0, 0, 0, 0,   0, 0, 0, 0,     4'b1111, 2'b00,  0, 0,   0, 0));
    // stall for three cycles with two writes on the ports
    vq.push_back(mk(0, 0, 4'b1111, 11,12,13,14,  50,51,52,53,     4'b1111, 2'b00,  0, 0,   0, 0));
    vq.push_back(mk(0, 0, 4'b0000,  0, 0, 0, 0,   0, 0, 0, 0,     4'b0000, 2'b00,  0, 0,   0, 0));
    vq.push_back(mk(0, 1, 4'b1100,  0, 0,15,16,   0, 0,54,55,     4'b1100, 2'b11, 13,52,  14,53));
    vq.push_back(mk(0, 1, 4'b0000,  0, 0, 0, 0,   0, 0, 0, 0,     4'b0000, 2'b11, 13,52,  14,53));
    vq.push_back(mk(0, 1, 4'b0000,  0, 0, 0, 0,   0, 0, 0, 0,     4'b0000, 2'b11, 13,52,  14,53));
    vq.push_back(mk(0, 0, 4'b0000,  0, 0, 0, 0,   0, 0, 0, 0,     4'b0000, 2'b11, 13,52,  14,53));
    vq.push_back(mk(0, 0, 4'b0011, 17,18, 0, 0,  56,57, 0, 0,     4'b0011, 2'b11, 11,50,  12,51));
    // recover (with stall) while four are buffered and two are on the ports
    vq.push_back(mk(0, 1, 4'b1100,  0, 0,19,20,   0, 0,58,59,     4'b1100, 2'b11, 15,54,  16,55));
    vq.push_back(mk(1, 1, 4'b1111, 21,22,23,24,  60,61,62,63,     4'b0000, 2'b11, 15,54,  16,55));
    vq.push_back(mk(0, 0, 4'b0000,  0, 0, 0, 0,   0, 0, 0, 0,     4'b1111, 2'b00,  0, 0,   0, 0));
    vq.push_back(mk(0, 0, 4'b0000,  0, 0, 0, 0,   0, 0, 0, 0,     4'b1111, 2'b00,  0, 0,   0, 0));

    recover = 1'b0; stall = 1'b0; req_valid = '0; req_idx = '0; req_data = '0; req_tag = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("reset ready", 128'(ready), 128'(0));
    check("reset wb_valid", 128'(wb_valid), 128'(0));
    check("reset idx/tag", 128'({wb_idx, wb_tag}), 128'(0));
    check("reset data", 128'(wb_data), 128'(0));
    rst_n = 1'b1;

    for (int k = 0; k < vq.size(); k++) begin
      cur = vq[k];
      apply(cur);
      #1;
      check($sformatf("v%0d ready", k), 128'(ready), 128'(cur.rdy));
      check($sformatf("v%0d wb_valid", k), 128'(wb_valid), 128'(cur.wv));
      for (int p = 0; p < 2; p++) begin
        if (cur.wv[p]) begin
          check($sformatf("v%0d port%0d payload", k, p),
                128'({wb_idx[1'(p)], wb_data[1'(p)], wb_tag[1'(p)]}),
                128'({cur.widx[p], data_of(cur.wtag[p]), cur.wtag[p]}));
        end
      end
      @(negedge clk);
    end

    // Reset in the middle of operation zeroes the payload registers.
    recover = 1'b0; stall = 1'b0;
    req_valid = 4'b0001; req_idx = '0; req_tag = '0; req_data = '0;
    req_idx[0] = 5'd2; req_tag[0] = 6'd7; req_data[0] = data_of(6'd7);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk); #1;
    check("midrst write", 128'({wb_valid[0], wb_idx[0], wb_data[0], wb_tag[0]}),
          128'({1'b1, 5'd2, data_of(6'd7), 6'd7}));
    rst_n = 1'b0; #1;
    check("midrst ready low", 128'(ready), 128'(0));
    @(negedge clk); #1;
    check("midrst wb_valid", 128'(wb_valid), 128'(0));
    check("midrst idx/tag", 128'({wb_idx, wb_tag}), 128'(0));
    check("midrst data", 128'(wb_data), 128'(0));
    rst_n = 1'b1; #1;
    check("post reset ready", 128'(ready), 128'(4'b1111));
    @(negedge clk); #1;
    check("post reset idle", 128'(wb_valid), 128'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, %0d/%0d so far", passed, total);
    $fatal(1);
  end

endmodule
